// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: states, opcodes,
// datapath mux selects and the packed control word produced per state.
package mc_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ir_write and pc_write_ready are only honoured while MemReady is high.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write_ready;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// Pure combinational map from controller state to its raw control word.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [3:0]        state,
    output logic [CTRL_W-1:0] ctrl_word
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        case (state_t'(state))
            S_FETCH: begin
                ctrl.mem_read       = 1'b1;
                ctrl.alu_src_b      = SRCB_FOUR;
                ctrl.alu_op         = ALUOP_ADD;
                ctrl.pc_source      = PCSRC_ALU;
                ctrl.ir_write       = 1'b1;
                ctrl.pc_write_ready = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SHIFT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign ctrl_word = ctrl;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: state register, next-state logic, memory-wait gating,
// PC enable and the sticky illegal-opcode flag.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       IllegalOp
);

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CTRL_W-1:0]  ctrl_word;
    ctrl_t              ctrl;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // Opcode can only be lw/sw here unless the IR changed underneath us.
            S_MEM_ADDR: begin
                if (Opcode == OP_LW)      state_d = S_MEM_READ;
                else if (Opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_FETCH;
            end
            S_MEM_READ:  if (MemReady) state_d = S_MEM_WB;
            S_MEM_WRITE: if (MemReady) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:     state_d = S_RESET;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .ctrl_word (ctrl_word)
    );

    always_comb begin
        ctrl      = ctrl_t'(ctrl_word);
        IorD      = ctrl.iord;
        MemRead   = ctrl.mem_read;
        MemWrite  = ctrl.mem_write;
        IRWrite   = ctrl.ir_write & MemReady;
        MemtoReg  = ctrl.mem_to_reg;
        RegDst    = ctrl.reg_dst;
        RegWrite  = ctrl.reg_write;
        ALUSrcA   = ctrl.alu_src_a;
        ALUSrcB   = ctrl.alu_src_b;
        ALUOp     = ctrl.alu_op;
        PCSource  = ctrl.pc_source;
        PCEn      = (ctrl.pc_write_ready & MemReady) | ctrl.pc_write
                  | (ctrl.pc_write_cond & Zero);
        State     = state_q;
        IllegalOp = illegal_q;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction state-sequence model.
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
    logic       ALUSrcA, PCEn, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_illegal = 1'b0;
    int   cyc = 0;

    multicycle_controller dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCEn(PCEn), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .State(State), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [16:0] dut_ctrl();
        return {IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, PCEn};
    endfunction

    // Control word each state must present, straight from the state table.
    function automatic logic [16:0] exp_ctrl(input state_t s, input logic mr, input logic z);
        logic iord, mrd, mwr, irw, m2r, rdst, rw, asa, pcen;
        logic [1:0] asb, aop, pcs;
        {iord, mrd, mwr, irw, m2r, rdst, rw, asa, pcen} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            S_FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pcen = mr; end
            S_DECODE:    asb = 2'b11;
            S_MEM_ADDR,
            S_ADDI_EX:   begin asa = 1; asb = 2'b10; end
            S_MEM_READ:  begin mrd = 1; iord = 1; end
            S_MEM_WRITE: begin mwr = 1; iord = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_EXECUTE:   begin asa = 1; aop = 2'b10; end
            S_R_WB:      begin rw = 1; rdst = 1; end
            S_ADDI_WB:   rw = 1;
            S_BRANCH:    begin asa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            S_JUMP:      begin pcs = 2'b10; pcen = 1; end
            default:     ;
        endcase
        return {iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, pcen};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // One clock cycle: enter the next state, drive inputs, check mid-cycle.
    task automatic step(input state_t st, input logic mr, input logic z, input logic [5:0] op);
        @(posedge Clk);
        #1;
        MemReady = mr;
        Zero     = z;
        Opcode   = op;
        cyc++;
        @(negedge Clk);
        check({"state_", st.name()}, 32'(State), 32'(st));
        check({"ctrl_", st.name()}, 32'(dut_ctrl()), 32'(exp_ctrl(st, mr, z)));
        check("illegal", 32'(IllegalOp), 32'(exp_illegal));
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        cyc = 0;
        for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, 1'($urandom), rnd_op());
        step(S_FETCH, 1'b1, 1'($urandom), rnd_op());
        step(S_DECODE, 1'b1, 1'($urandom), op);
        if (!is_legal(op)) exp_illegal = 1'b1;
        case (op)
            6'b000000: begin
                step(S_EXECUTE, 1'b1, 1'($urandom), rnd_op());
                step(S_R_WB, 1'b1, 1'($urandom), rnd_op());
            end
            6'b100011: begin
                step(S_MEM_ADDR, 1'b1, 1'($urandom), op);
                for (int i = 0; i < mw; i++) step(S_MEM_READ, 1'b0, 1'($urandom), rnd_op());
                step(S_MEM_READ, 1'b1, 1'($urandom), rnd_op());
                step(S_MEM_WB, 1'b1, 1'($urandom), rnd_op());
            end
            6'b101011: begin
                step(S_MEM_ADDR, 1'b1, 1'($urandom), op);
                for (int i = 0; i < mw; i++) step(S_MEM_WRITE, 1'b0, 1'($urandom), rnd_op());
                step(S_MEM_WRITE, 1'b1, 1'($urandom), rnd_op());
            end
            6'b000100: step(S_BRANCH, 1'b1, z, rnd_op());
            6'b000010: step(S_JUMP, 1'b1, 1'($urandom), rnd_op());
            6'b001000: begin
                step(S_ADDI_EX, 1'b1, 1'($urandom), rnd_op());
                step(S_ADDI_WB, 1'b1, 1'($urandom), rnd_op());
            end
            default: ;
        endcase
        $display("instr op=%b fetch_wait=%0d mem_wait=%0d zero=%0b cycles=%0d illegal=%0b",
                 op, fw, mw, z, cyc, exp_illegal);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops [6];
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        Rst = 1'b1; MemReady = 1'b1; Zero = 1'b1; Opcode = 6'b000100;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_state", 32'(State), 32'(S_RESET));
        check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
        check("rst_illegal", 32'(IllegalOp), 32'd0);
        Rst = 1'b0;
        #1;
        check("rst_release_state", 32'(State), 32'(S_RESET));

        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 0, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b101011, 1, 2, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b001000, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int idx;
            idx = int'($urandom_range(0, 6));
            if (idx == 6) begin
                do op = rnd_op(); while (is_legal(op));
            end else begin
                op = legal_ops[idx];
            end
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Asynchronous reset in the middle of a stalled load.
        step(S_FETCH, 1'b1, 1'b0, rnd_op());
        step(S_DECODE, 1'b1, 1'b0, 6'b100011);
        step(S_MEM_ADDR, 1'b1, 1'b0, 6'b100011);
        step(S_MEM_READ, 1'b0, 1'b1, rnd_op());
        #2;
        MemReady = 1'b1;
        Rst = 1'b1;
        #1;
        exp_illegal = 1'b0;
        check("midrst_state", 32'(State), 32'(S_RESET));
        check("midrst_ctrl", 32'(dut_ctrl()), 32'd0);
        check("midrst_illegal", 32'(IllegalOp), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("midrst_release_state", 32'(State), 32'(S_RESET));
        run_instr(6'b001000, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
